// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ack data-memory port, aligns
// and extends load data, and registers the outcome into the MEM/WB latch.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic        load_inst,
    input  logic        store_inst,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [4:0]  dest_reg,
    input  logic        dest_reg_valid,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_dest_reg,
    output logic        wb_dest_reg_valid,
    output logic        misalign_exc,
    output logic        bus_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Counter only ever holds 0..TIMEOUT_CYCLES-1.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic [3:0]     be_q, be_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           we_q, we_d;
    logic [1:0]     size_q, size_d;
    logic           uns_q, uns_d;
    logic [4:0]     dest_q, dest_d;
    logic           ldv_q, ldv_d;
    logic           wbv_q, wbv_d;
    logic [31:0]    wbr_q, wbr_d;
    logic [4:0]     wbd_q, wbd_d;
    logic           wbdv_q, wbdv_d;
    logic           mis_q, mis_d;
    logic           berr_q, berr_d;

    logic        busy, accept, is_mem, misaligned, start, expire;
    logic [31:0] lane, load_val;

    assign busy       = (state_q == BUSY);
    assign accept     = (state_q == IDLE) && ex_valid;
    assign is_mem     = load_inst || store_inst;
    assign misaligned = ((mem_size == 2'd1) && ex_result[0]) ||
                        (mem_size[1] && (ex_result[1:0] != 2'b00));
    assign start      = accept && is_mem && !misaligned;
    assign expire     = busy && !dmem_ack && (TIMEOUT_CYCLES != 0) &&
                        (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Byte lanes are shifted down to bit 0 before extension.
    assign lane = (size_q == 2'd1) ? (dmem_rdata >> {addr_q[1], 4'b0000})
                                   : (dmem_rdata >> {addr_q[1:0], 3'b000});

    always_comb begin
        case (size_q)
            2'd0:    load_val = uns_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'd1:    load_val = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        dest_d  = dest_q;
        ldv_d   = ldv_q;
        wbv_d   = 1'b0;
        wbr_d   = wbr_q;
        wbd_d   = wbd_q;
        wbdv_d  = wbdv_q;
        mis_d   = 1'b0;
        berr_d  = 1'b0;

        if (accept) begin
            if (!is_mem || misaligned) begin
                wbv_d  = 1'b1;
                wbr_d  = ex_result;
                wbd_d  = dest_reg;
                wbdv_d = !is_mem && dest_reg_valid;
                mis_d  = is_mem;
            end else begin
                state_d = BUSY;
                cnt_d   = '0;
                addr_d  = ex_result;
                we_d    = !load_inst;
                size_d  = mem_size;
                uns_d   = mem_unsigned;
                dest_d  = dest_reg;
                ldv_d   = load_inst && dest_reg_valid;
                // Byte enables qualify writes only; reads always fetch the whole word.
                be_d    = 4'h0;
                wdata_d = ex_store_data;
                if (!load_inst) begin
                    case (mem_size)
                        2'd0: begin
                            be_d    = 4'b0001 << ex_result[1:0];
                            wdata_d = {4{ex_store_data[7:0]}};
                        end
                        2'd1: begin
                            be_d    = ex_result[1] ? 4'b1100 : 4'b0011;
                            wdata_d = {2{ex_store_data[15:0]}};
                        end
                        default: be_d = 4'hF;
                    endcase
                end
            end
        end else if (busy) begin
            if (dmem_ack) begin
                state_d = IDLE;
                cnt_d   = '0;
                wbv_d   = 1'b1;
                wbr_d   = we_q ? addr_q : load_val;
                wbd_d   = dest_q;
                wbdv_d  = ldv_q;
            end else if (expire) begin
                state_d = IDLE;
                cnt_d   = '0;
                wbv_d   = 1'b1;
                wbr_d   = addr_q;
                wbd_d   = dest_q;
                wbdv_d  = 1'b0;
                berr_d  = 1'b1;
            end else if (TIMEOUT_CYCLES != 0) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            dest_q  <= '0;
            ldv_q   <= 1'b0;
            wbv_q   <= 1'b0;
            wbr_q   <= '0;
            wbd_q   <= '0;
            wbdv_q  <= 1'b0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            dest_q  <= dest_d;
            ldv_q   <= ldv_d;
            wbv_q   <= wbv_d;
            wbr_q   <= wbr_d;
            wbd_q   <= wbd_d;
            wbdv_q  <= wbdv_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    // Stall is released on the completing cycle (ack or expiry) so EX advances exactly once.
    assign stall_out         = reset_n && (start || (busy && !dmem_ack && !expire));
    assign dmem_req          = busy;
    assign dmem_we           = busy && we_q;
    assign dmem_addr         = busy ? {addr_q[31:2], 2'b00} : 32'h0;
    assign dmem_be           = busy ? be_q : 4'h0;
    assign dmem_wdata        = busy ? wdata_q : 32'h0;
    assign wb_valid          = wbv_q;
    assign wb_result         = wbr_q;
    assign wb_dest_reg       = wbd_q;
    assign wb_dest_reg_valid = wbdv_q;
    assign misalign_exc      = mis_q;
    assign bus_err           = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a per-cycle reference model and a handful
// of literal expectations for the documented scenarios.
module tb_mem_stage;

    localparam int unsigned T = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_result = '0;
    logic [31:0] ex_store_data = '0;
    logic        load_inst = 1'b0;
    logic        store_inst = 1'b0;
    logic [1:0]  mem_size = '0;
    logic        mem_unsigned = 1'b0;
    logic [4:0]  dest_reg = '0;
    logic        dest_reg_valid = 1'b0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall_out, dmem_req, dmem_we, wb_valid, wb_dest_reg_valid;
    logic        misalign_exc, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, wb_result;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_dest_reg;

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .load_inst(load_inst), .store_inst(store_inst),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .dest_reg(dest_reg),
        .dest_reg_valid(dest_reg_valid), .stall_out(stall_out), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_result(wb_result), .wb_dest_reg(wb_dest_reg),
        .wb_dest_reg_valid(wb_dest_reg_valid), .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle
    bit          chk_en = 0;
    bit          e_stall, e_req, e_we, e_wbv, e_dv, e_mis, e_berr, e_chk_res, e_chk_dest;
    logic [31:0] e_addr, e_wdata, e_res;
    logic [3:0]  e_be;
    logic [4:0]  e_dest;
    int          stall_cnt, req_cnt;
    logic [3:0]  last_be;
    logic [31:0] last_wdata;

    task automatic set_idle_exp();
        e_stall = 0; e_req = 0; e_we = 0; e_wbv = 0; e_dv = 0; e_mis = 0; e_berr = 0;
        e_chk_res = 0; e_chk_dest = 0; e_addr = '0; e_wdata = '0; e_res = '0; e_be = '0; e_dest = '0;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("stall_out", {31'b0, stall_out}, {31'b0, e_stall});
            check("dmem_req", {31'b0, dmem_req}, {31'b0, e_req});
            if (stall_out) stall_cnt++;
            if (dmem_req) begin
                req_cnt++;
                last_be = dmem_be;
                last_wdata = dmem_wdata;
            end
            if (e_req) begin
                check("dmem_we", {31'b0, dmem_we}, {31'b0, e_we});
                check("dmem_addr", dmem_addr, e_addr);
                check("dmem_be", {28'b0, dmem_be}, {28'b0, e_be});
                if (e_we) check("dmem_wdata", dmem_wdata, e_wdata);
            end
            check("wb_valid", {31'b0, wb_valid}, {31'b0, e_wbv});
            check("misalign_exc", {31'b0, misalign_exc}, {31'b0, e_mis});
            check("bus_err", {31'b0, bus_err}, {31'b0, e_berr});
            if (e_wbv) begin
                check("wb_dest_reg_valid", {31'b0, wb_dest_reg_valid}, {31'b0, e_dv});
                if (e_chk_res) check("wb_result", wb_result, e_res);
                if (e_chk_dest) check("wb_dest_reg", {27'b0, wb_dest_reg}, {27'b0, e_dest});
            end
        end
    end

    // Reference model: plain arithmetic from the memory-access rules
    function automatic logic [31:0] load_value(input logic [31:0] addr, input logic [31:0] rdata,
                                               input logic [1:0] size, input logic uns);
        int unsigned sh;
        logic [31:0] mask, v;
        if (size == 2'd0) begin sh = 8 * addr[1:0]; mask = 32'hFF; end
        else if (size == 2'd1) begin sh = 16 * addr[1]; mask = 32'hFFFF; end
        else begin sh = 0; mask = 32'hFFFF_FFFF; end
        v = (rdata >> sh) & mask;
        if (!uns && mask != 32'hFFFF_FFFF && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] be_value(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'd0) return 4'(1 << (addr % 4));
        if (size == 2'd1) return (addr % 4 >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] wdata_value(input logic [31:0] d, input logic [1:0] size);
        if (size == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit is_misaligned(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'd1) return (addr % 2) != 0;
        if (size >= 2'd2) return (addr % 4) != 0;
        return 0;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ack_delay: BUSY cycle index (0 = first request cycle) carrying ack; -1 = never.
    task automatic do_op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] dest, input bit dv,
                         input int ack_delay, input logic [31:0] rdata);
        bit mem, mis, acked, expired;
        int k;
        mem = ld || st;
        mis = mem && is_misaligned(addr, sz);
        ex_valid = 1; ex_result = addr; ex_store_data = data; load_inst = ld; store_inst = st;
        mem_size = sz; mem_unsigned = uns; dest_reg = dest; dest_reg_valid = dv; dmem_ack = 0;
        set_idle_exp();
        e_stall = mem && !mis;
        step();
        if (!mem || mis) begin
            ex_valid = 0;
            set_idle_exp();
            e_wbv = 1; e_mis = mis; e_dv = mis ? 1'b0 : dv;
            e_chk_res = 1; e_res = addr; e_chk_dest = !mis; e_dest = dest;
        end else begin
            acked = 0; expired = 0; k = 0;
            while (!acked && !expired) begin
                acked = (k == ack_delay);
                expired = !acked && (k == int'(T) - 1);
                dmem_ack = acked;
                dmem_rdata = acked ? rdata : ~rdata;
                set_idle_exp();
                e_req = 1; e_we = st; e_addr = addr & ~32'h3;
                e_be = st ? be_value(addr, sz) : 4'h0;
                e_wdata = wdata_value(data, sz);
                e_stall = !(acked || expired);
                step();
                k++;
            end
            dmem_ack = 0; ex_valid = 0;
            set_idle_exp();
            e_wbv = 1;
            if (acked) begin
                e_dv = ld ? dv : 1'b0;
                e_chk_res = 1;
                e_res = ld ? load_value(addr, rdata, sz, uns) : addr;
                e_chk_dest = ld; e_dest = dest;
            end else begin
                e_berr = 1; e_dv = 0;
            end
        end
        step();
        set_idle_exp();
    endtask

    initial begin
        set_idle_exp();
        #2;
        check("rst_stall", {31'b0, stall_out}, 32'h0);
        check("rst_req", {31'b0, dmem_req}, 32'h0);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
        check("rst_wb_result", wb_result, 32'h0);
        check("rst_wb_dest", {27'b0, wb_dest_reg}, 32'h0);
        check("rst_exc", {30'b0, misalign_exc, bus_err}, 32'h0);
        check("rst_dmem_be", {28'b0, dmem_be}, 32'h0);
        @(negedge clock);
        reset_n = 1;
        step();
        chk_en = 1;

        // ALU pass-through
        stall_cnt = 0;
        do_op(0, 0, 2'd0, 0, 32'h1234, 32'h0, 5'd5, 1, 0, 32'h0);
        check("lit_alu_result", wb_result, 32'h1234);
        check("lit_alu_dest", {27'b0, wb_dest_reg}, 32'd5);
        check("lit_alu_nostall", stall_cnt, 0);
        do_op(0, 0, 2'd0, 0, 32'hCAFE_0001, 32'h0, 5'd9, 0, 0, 32'h0);

        // lb / lbu at 0x103, ack two cycles after request
        stall_cnt = 0; req_cnt = 0;
        do_op(1, 0, 2'd0, 0, 32'h103, 32'h0, 5'd7, 1, 2, 32'h80AA_BBCC);
        check("lit_lb_result", wb_result, 32'hFFFF_FF80);
        check("lit_lb_stall", stall_cnt, 3);
        check("lit_lb_be", {28'b0, last_be}, 32'h0);
        do_op(1, 0, 2'd0, 1, 32'h103, 32'h0, 5'd7, 1, 2, 32'h80AA_BBCC);
        check("lit_lbu_result", wb_result, 32'h0000_0080);

        // Halfword and other byte lanes, fastest ack
        do_op(1, 0, 2'd1, 0, 32'h106, 32'h0, 5'd3, 1, 0, 32'h8001_7FFF);
        check("lit_lh_result", wb_result, 32'hFFFF_8001);
        do_op(1, 0, 2'd1, 1, 32'h104, 32'h0, 5'd3, 1, 1, 32'h8001_F00F);
        check("lit_lhu_result", wb_result, 32'h0000_F00F);
        do_op(1, 0, 2'd0, 0, 32'h101, 32'h0, 5'd4, 1, 0, 32'h1234_5678);

        // sh 0x202
        do_op(0, 1, 2'd1, 0, 32'h202, 32'hDEAD_BEEF, 5'd6, 1, 1, 32'h0);
        check("lit_sh_be", {28'b0, last_be}, 32'hC);
        check("lit_sh_wdata", last_wdata, 32'hBEEF_BEEF);
        check("lit_sh_result", wb_result, 32'h202);
        do_op(0, 1, 2'd0, 0, 32'h001, 32'h0000_00A5, 5'd0, 0, 0, 32'h0);
        check("lit_sb_wdata", last_wdata, 32'hA5A5_A5A5);
        do_op(0, 1, 2'd2, 0, 32'h010, 32'h1357_9BDF, 5'd0, 0, 0, 32'h0);

        // Misaligned word and half
        req_cnt = 0;
        do_op(1, 0, 2'd2, 0, 32'h101, 32'h0, 5'd8, 1, 0, 32'h0);
        check("lit_mis_noreq", req_cnt, 0);
        check("lit_mis_result", wb_result, 32'h101);
        do_op(0, 1, 2'd1, 0, 32'h203, 32'h0, 5'd0, 0, 0, 32'h0);

        // Timeout: never ack, then ack on the expiry cycle
        req_cnt = 0;
        do_op(1, 0, 2'd2, 0, 32'h300, 32'h0, 5'd10, 1, -1, 32'h0);
        check("lit_to_reqcycles", req_cnt, 4);
        do_op(1, 0, 2'd2, 0, 32'h300, 32'h0, 5'd10, 1, 3, 32'h1122_3344);
        check("lit_ack_at_expiry", wb_result, 32'h1122_3344);

        // Reset while BUSY
        ex_valid = 1; ex_result = 32'h400; load_inst = 1; store_inst = 0;
        mem_size = 2'd2; mem_unsigned = 0; dest_reg = 5'd11; dest_reg_valid = 1;
        set_idle_exp(); e_stall = 1;
        step();
        set_idle_exp(); e_req = 1; e_addr = 32'h400; e_stall = 1;
        #2;
        chk_en = 0;
        reset_n = 0;
        #1;
        check("rst_busy_req", {31'b0, dmem_req}, 32'h0);
        check("rst_busy_stall", {31'b0, stall_out}, 32'h0);
        check("rst_busy_wbv", {31'b0, wb_valid}, 32'h0);
        ex_valid = 0; load_inst = 0;
        @(negedge clock);
        reset_n = 1;
        step();
        set_idle_exp();
        chk_en = 1;
        do_op(1, 0, 2'd2, 0, 32'h400, 32'h0, 5'd11, 1, 0, 32'hCAFE_F00D);
        check("lit_post_reset_lw", wb_result, 32'hCAFE_F00D);

        step();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
